// File: rtl/sample_conditioner.sv
// -----------------------------------------------------------------------------
// sample_conditioner
//
// This block sits between the serial ADC interface and the sliding DFT. It
// averages raw ADC samples in blocks, removes the DC bias with a leaky
// integrator, and scales and saturates the result to an offset-binary sample.
// Each sample is then handed to the SDFT through its start/ready handshake.
// A single pending slot absorbs backpressure. When a pending sample is
// overwritten, the block flags an overrun and counts the drop.
//
// Pipeline, for a block that completes on cycle t:
//   t+1  avg registered (block average)
//   t+2  ac = avg - dc_est, shifted and saturated into result; dc updated
//   t+3  result loaded into the pending slot
//   then the handshake FSM launches the pending sample when the SDFT is idle
//
// Ports:
//   clk         in   1      pixel clock, all logic on posedge
//   reset       in   1      asynchronous, active-high, clears all state
//   in_valid    in   1      one-cycle strobe qualifying in_data
//   in_data     in   IN_W   unsigned ADC sample
//   sdft_ready  in   1      SDFT idle and able to accept a sample
//   sdft_start  out  1      request SDFT to process sample_out
//   sample_out  out  OUT_W  offset-binary sample, stable while sdft_start=1
//   overrun     out  1      sticky, set when a pending sample is overwritten
//   drop_count  out  CNT_W  overwritten samples, saturating at all-ones
// -----------------------------------------------------------------------------
module sample_conditioner #(
  parameter int IN_W       = 12,
  parameter int OUT_W      = 8,
  parameter int DECIM_LOG2 = 2,
  parameter int DC_SHIFT   = 6,
  parameter int GAIN_SHIFT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             sdft_ready,
  output logic             sdft_start,
  output logic [OUT_W-1:0] sample_out,
  output logic             overrun,
  output logic [CNT_W-1:0] drop_count
);

  localparam int ACC_W = IN_W + DECIM_LOG2;
  localparam int DC_W  = IN_W + DC_SHIFT;
  localparam int AC_W  = IN_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

  // Saturation limits for the shifted AC value, in the AC width.
  localparam logic signed [AC_W-1:0] SAT_HI = AC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [AC_W-1:0] SAT_LO = AC_W'(-(1 << (OUT_W-1)));

  // ---------------------------------------------------------------------------
  // Stage 1: block averaging
  // ---------------------------------------------------------------------------
  logic [DECIM_LOG2-1:0] dec_cnt;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_sum;
  logic                  block_done;
  logic [IN_W-1:0]       avg;
  logic                  avg_v;

  // The last strobe of a block is folded into the sum directly, so
  // back-to-back strobes never wait on the accumulator.
  assign acc_sum    = acc + {{DECIM_LOG2{1'b0}}, in_data};
  assign block_done = in_valid && (dec_cnt == '1);

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values of the others, so the stage order inside
  // the block does not matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_cnt <= '0;
      acc     <= '0;
      avg     <= '0;
      avg_v   <= 1'b0;
    end else begin
      avg_v <= block_done;
      if (in_valid) begin
        dec_cnt <= dec_cnt + 1'b1;
        acc     <= block_done ? '0 : acc_sum;
      end
      if (block_done) begin
        avg <= acc_sum[ACC_W-1:DECIM_LOG2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: DC removal, gain and saturation
  // ---------------------------------------------------------------------------
  logic [DC_W-1:0]        dc;
  logic                   dc_valid;
  logic [IN_W-1:0]        dc_est;
  logic [IN_W-1:0]        dc_base;
  logic signed [AC_W-1:0] ac;
  logic signed [AC_W-1:0] ac_sh;
  logic [OUT_W-1:0]       result_c;
  logic [DC_W-1:0]        dc_next;
  logic [OUT_W-1:0]       result;
  logic                   result_v;

  assign dc_est = dc[DC_W-1:DC_SHIFT];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave one unassigned and infer a latch.
  always_comb begin
    dc_base  = dc_est;
    ac       = '0;
    ac_sh    = '0;
    result_c = MIDSCALE;
    dc_next  = dc;

    // The first average after reset preloads the tracker. Subtracting the
    // average from itself makes that first AC value exactly zero.
    if (!dc_valid) begin
      dc_base = avg;
    end
    ac    = $signed({1'b0, avg}) - $signed({1'b0, dc_base});
    ac_sh = ac >>> GAIN_SHIFT;

    // In offset binary, positive full scale is all-ones and negative full
    // scale is zero. In range, flipping the sign bit adds midscale.
    if (ac_sh > SAT_HI) begin
      result_c = '1;
    end else if (ac_sh < SAT_LO) begin
      result_c = '0;
    end else begin
      result_c = ac_sh[OUT_W-1:0] ^ MIDSCALE;
    end

    if (dc_valid) begin
      dc_next = dc + {{DC_SHIFT{1'b0}}, avg} - {{DC_SHIFT{1'b0}}, dc_est};
    end else begin
      dc_next = {avg, {DC_SHIFT{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc       <= '0;
      dc_valid <= 1'b0;
      result   <= MIDSCALE;
      result_v <= 1'b0;
    end else begin
      result_v <= avg_v;
      if (avg_v) begin
        dc       <= dc_next;
        dc_valid <= 1'b1;
        result   <= result_c;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: pending slot and SDFT handshake
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic [OUT_W-1:0] pending;
  logic             pending_v;
  logic             consume;

  assign consume = (state == S_IDLE) && pending_v && sdft_ready;

  // NOTE: the pending slot is a plain data register, yet it is still reset.
  // After a reset, nothing from the aborted stream can reappear on
  // sample_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sdft_start <= 1'b0;
      sample_out <= MIDSCALE;
      pending    <= MIDSCALE;
      pending_v  <= 1'b0;
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (consume) begin
            sample_out <= pending;
            sdft_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          // The SDFT drops ready once it has taken the sample.
          if (!sdft_ready) begin
            sdft_start <= 1'b0;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (sdft_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          sdft_start <= 1'b0;
          state      <= S_IDLE;
        end
      endcase

      // A new result always wins the slot. It is counted as a drop only if
      // the old value is still there and not leaving this cycle.
      if (result_v) begin
        pending   <= result;
        pending_v <= 1'b1;
        if (pending_v && !consume) begin
          overrun <= 1'b1;
          if (drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
          end
        end
      end else if (consume) begin
        pending_v <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sample_conditioner.md
Name: sample_conditioner

Overview:
- Sits between the serial ADC interface and the sliding DFT.
- Decimates raw 12b ADC samples by block averaging and removes the DC bias with a leaky integrator.
- Scales and saturates the result to an 8b offset-binary sample.
- Delivers each sample to the SDFT via its start/ready handshake, which replaces the ad-hoc FFT feed FSM in the top level. Flags overruns when the SDFT cannot keep up.

Parameters:
- IN_W, 12, ADC sample width (unsigned)
- OUT_W, 8, output sample width, offset binary (midscale 2^(OUT_W-1))
- DECIM_LOG2, 2, averages 2^DECIM_LOG2 input samples per output sample
- DC_SHIFT, 6, DC tracker time constant: dc += (avg - dc)/2^DC_SHIFT
- GAIN_SHIFT, 4, arithmetic right shift applied to the AC value before saturation
- CNT_W, 16, drop counter width

Ports:
- clk, input, 1, pixel clock; all logic on posedge
- reset, input, 1, asynchronous, active-high; clears all state
- in_valid, input, 1, one-cycle strobe; in_data is valid this cycle
- in_data, input, IN_W, unsigned ADC sample
- sdft_ready, input, 1, SDFT idle and able to accept a sample
- sdft_start, output, 1, request SDFT to process sample_out
- sample_out, output, OUT_W, sample presented to SDFT; stable while sdft_start=1
- overrun, output, 1, sticky; set when a pending sample is overwritten
- drop_count, output, CNT_W, number of overwritten samples; saturates at all-ones

Behaviour:
- Reset values: sdft_start=0, sample_out=2^(OUT_W-1), overrun=0, drop_count=0. Accumulator, decimation counter, dc, dc_valid and pending are all cleared, and the FSM goes to S_IDLE. Reset asserted mid-handshake aborts immediately; no sample is retained.
- Decimation:
  - acc (IN_W+DECIM_LOG2 bits) adds in_data on each in_valid.
  - When the count wraps (the 2^DECIM_LOG2-th strobe), avg = (acc + in_data) >> DECIM_LOG2 is registered (stage 1, cycle t+1) and acc restarts from 0.
- DC tracker: dc is held as IN_W+DC_SHIFT bits, with dc_est = dc >> DC_SHIFT.
  - First avg after reset: dc <= avg << DC_SHIFT and dc_valid <= 1 (preload), so that AC = 0.
  - Otherwise: dc <= dc + avg - dc_est.
- AC path (stage 2, t+2):
  - ac = avg - dc_est, using the pre-update dc_est, signed IN_W+1 bits.
  - s = ac >>> GAIN_SHIFT, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - result = s + 2^(OUT_W-1), unsigned OUT_W.
- Pending (stage 3, t+3): result is loaded into the pending register and pending_v=1.
  - If pending_v was already 1 and is not being consumed this cycle: overwrite, overrun <= 1, drop_count++ (saturating).
  - Load and consume in the same cycle: the new value becomes pending, with no overrun.
- Handshake FSM:
  - S_IDLE: if pending_v and sdft_ready, then sample_out <= pending, sdft_start <= 1, pending_v <= 0 (consume), go to S_START.
  - S_START: hold sdft_start=1 and sample_out until sdft_ready=0, then sdft_start <= 0 and go to S_BUSY.
  - S_BUSY: wait for sdft_ready=1, then go to S_IDLE. A pending sample may be launched on the next cycle.
  - sample_out changes only on the IDLE to START transition.
- in_valid strobes are never stalled or lost. Backpressure is absorbed solely by the single pending slot plus overrun accounting.
- in_valid asserted on consecutive cycles must be accepted, i.e. one sample per cycle.

Test Plan:
- Preload: 4 strobes of in_data=2048 with sdft_ready=1 → one sdft_start; sample_out=128; dc_est=2048.
- Step: after the preload, 4 strobes of 2304 → ac=256, s=16, sample_out=144. Repeated 2304 blocks decay monotonically toward 128, and the next output is ≤143.
- Saturation: preload with 2048, then a block of 4095 → sample_out=255. Preload with 4095, then a block of 0 → sample_out=0.
- Handshake: model an SDFT that drops ready 2 cycles after start and raises it 10 cycles later → sdft_start is high for exactly those 2+1 cycles, sample_out is stable throughout, and there is exactly one start per decimated sample.
- Overrun: hold sdft_ready=0 and feed 12 strobes (3 decimated samples) → overrun=1, drop_count=2. Release ready → exactly one start, carrying the value of the 3rd block.
- Reset mid-op: assert reset during S_START → sdft_start=0 asynchronously; on release, a block of 1000×4 preloads again and outputs 128.
